// File: rtl/piso_bit_streamer_if.sv
// Handshake and serial-output bundle for the PISO bit streamer.
// master: word producer / serial consumer side. slave: the streamer itself.
interface piso_bit_streamer_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             busy;
    logic             done;

    modport master (
        output data_in,
        output load_valid,
        input  load_ready,
        input  ser_out,
        input  ser_valid,
        input  busy,
        input  done
    );

    modport slave (
        input  data_in,
        input  load_valid,
        output load_ready,
        output ser_out,
        output ser_valid,
        output busy,
        output done
    );

endinterface

// File: rtl/piso_bit_streamer.sv
// Parallel-in/serial-out bit streamer: accepts a WIDTH-bit word over a valid/ready
// handshake, shifts it out one bit per clock, then idles for GAP cycles.
// ser_out/ser_valid/busy/done are registered; load_ready is decoded from state.
module piso_bit_streamer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b0,
    parameter int unsigned GAP       = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    piso_bit_streamer_if.slave   bus
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap
    } state_e;

    localparam logic [4:0] LastBit = 5'(WIDTH - 1);
    localparam bit         HasGap  = (GAP > 0);
    localparam logic [3:0] GapLast = 4'((GAP > 0) ? (GAP - 1) : 0);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [4:0]       r_bit_cnt;
    logic [4:0]       w_bit_cnt_nxt;
    logic [3:0]       r_gap_cnt;
    logic [3:0]       w_gap_cnt_nxt;
    logic             r_ser_out;
    logic             w_ser_out_nxt;
    logic             r_ser_valid;
    logic             w_ser_valid_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;

    logic             w_last_bit;
    logic             w_load_ready;
    logic             w_accept;
    logic             w_do_load;
    logic             w_first_bit;
    logic [WIDTH-1:0] w_shifted;
    logic             w_next_bit;

    // Handshake decode; with no gap the last-bit cycle also takes the next word.
    always_comb begin
        w_last_bit   = (r_state == StShift) && (r_bit_cnt == LastBit);
        w_load_ready = (r_state == StIdle) || (!HasGap && w_last_bit);
        w_accept     = bus.load_valid && w_load_ready;
        w_first_bit  = LSB_FIRST ? bus.data_in[0] : bus.data_in[WIDTH-1];
        w_shifted    = LSB_FIRST ? (r_shift >> 1) : (r_shift << 1);
        w_next_bit   = LSB_FIRST ? w_shifted[0] : w_shifted[WIDTH-1];
    end

    // Next-state and next registered outputs.
    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_gap_cnt_nxt   = r_gap_cnt;
        w_ser_out_nxt   = 1'b0;
        w_ser_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        w_done_nxt      = 1'b0;
        w_do_load       = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_do_load = w_accept;
            end
            StShift: begin
                if (w_last_bit) begin
                    if (HasGap) begin
                        w_state_nxt   = StGap;
                        w_gap_cnt_nxt = 4'd0;
                        w_busy_nxt    = 1'b1;
                    end else if (w_accept) begin
                        w_do_load = 1'b1;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end else begin
                    w_bit_cnt_nxt   = r_bit_cnt + 5'd1;
                    w_shift_nxt     = w_shifted;
                    w_ser_out_nxt   = w_next_bit;
                    w_ser_valid_nxt = 1'b1;
                    w_busy_nxt      = 1'b1;
                    w_done_nxt      = ((r_bit_cnt + 5'd1) == LastBit);
                end
            end
            StGap: begin
                if (r_gap_cnt == GapLast) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 4'd1;
                    w_busy_nxt    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        // A load presents bit 0 in the very next cycle; WIDTH >= 2 so it is never last.
        if (w_do_load) begin
            w_state_nxt     = StShift;
            w_shift_nxt     = bus.data_in;
            w_bit_cnt_nxt   = 5'd0;
            w_ser_out_nxt   = w_first_bit;
            w_ser_valid_nxt = 1'b1;
            w_busy_nxt      = 1'b1;
            w_done_nxt      = 1'b0;
        end
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= StIdle;
            r_shift     <= '0;
            r_bit_cnt   <= 5'd0;
            r_gap_cnt   <= 4'd0;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_ser_out   <= w_ser_out_nxt;
            r_ser_valid <= w_ser_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign bus.load_ready = w_load_ready;
    assign bus.ser_out    = r_ser_out;
    assign bus.ser_valid  = r_ser_valid;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule

// File: tb/tb_piso_bit_streamer.sv
// Scoreboard bench for piso_bit_streamer: two instances (8-bit MSB-first no gap,
// 4-bit LSB-first gap 2) driven with directed and random words.
module tb_piso_bit_streamer;

    localparam int WA = 8;
    localparam int WB = 4;
    localparam int GB = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    piso_bit_streamer_if #(.WIDTH(WA)) bus_a ();
    piso_bit_streamer_if #(.WIDTH(WB)) bus_b ();

    piso_bit_streamer #(.WIDTH(WA), .LSB_FIRST(1'b0), .GAP(0)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    piso_bit_streamer #(.WIDTH(WB), .LSB_FIRST(1'b1), .GAP(GB)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    typedef struct {
        logic b;
        logic last;
        int   cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a;
    exp_t e_b;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    bit in_reset = 1'b1;

    // Reference timeline: next cycle a word can be accepted, and busy window.
    int nf_a = 0;
    int nf_b = 0;
    int bf_a = 1;
    int bt_a = 0;
    int bf_b = 1;
    int bt_b = 0;
    bit er_a = 1'b1;
    bit er_b = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
        end
    endtask

    // One driven cycle: inputs set just after the edge, model decides acceptance.
    task automatic drive_cycle(input bit va, input logic [WA-1:0] da,
                               input bit vb, input logic [WB-1:0] db,
                               output bit acc_a, output bit acc_b);
        exp_t e;
        @(posedge clk);
        #1;
        er_a = (cyc >= nf_a);
        er_b = (cyc >= nf_b);
        bus_a.load_valid = va;
        bus_a.data_in    = da;
        bus_b.load_valid = vb;
        bus_b.data_in    = db;
        acc_a = va && er_a;
        acc_b = vb && er_b;
        if (acc_a) begin
            for (int i = 0; i < WA; i++) begin
                e.b    = da[WA-1-i];
                e.last = (i == WA - 1);
                e.cyc  = cyc + 1 + i;
                q_a.push_back(e);
            end
            nf_a = cyc + WA;
            if (cyc + 1 > bt_a + 1) bf_a = cyc + 1;
            bt_a = cyc + WA;
        end
        if (acc_b) begin
            for (int i = 0; i < WB; i++) begin
                e.b    = db[i];
                e.last = (i == WB - 1);
                e.cyc  = cyc + 1 + i;
                q_b.push_back(e);
            end
            nf_b = cyc + WB + GB + 1;
            if (cyc + 1 > bt_b + 1) bf_b = cyc + 1;
            bt_b = cyc + WB + GB;
        end
    endtask

    task automatic idle(input int n);
        bit aa;
        bit ab;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, 1'b0, '0, aa, ab);
    endtask

    // Hold each valid high until that instance accepts, bounded.
    task automatic offer(input bit use_a, input logic [WA-1:0] da,
                         input bit use_b, input logic [WB-1:0] db);
        bit pa;
        bit pb;
        bit aa;
        bit ab;
        int n;
        pa = use_a;
        pb = use_b;
        n = 0;
        while ((pa || pb) && n < 64) begin
            drive_cycle(pa, da, pb, db, aa, ab);
            if (aa) pa = 1'b0;
            if (ab) pb = 1'b0;
            n++;
        end
        if (pa || pb) check("offer_timeout", 1, 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_a_ser_out", int'(bus_a.ser_out), 0);
        check("rst_a_ser_valid", int'(bus_a.ser_valid), 0);
        check("rst_a_busy", int'(bus_a.busy), 0);
        check("rst_a_done", int'(bus_a.done), 0);
        check("rst_a_ready", int'(bus_a.load_ready), 1);
        check("rst_b_ser_out", int'(bus_b.ser_out), 0);
        check("rst_b_ser_valid", int'(bus_b.ser_valid), 0);
        check("rst_b_busy", int'(bus_b.busy), 0);
        check("rst_b_done", int'(bus_b.done), 0);
        check("rst_b_ready", int'(bus_b.load_ready), 1);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        nf_a = cyc;
        nf_b = cyc;
        er_a = 1'b1;
        er_b = 1'b1;
        in_reset = 1'b0;
    endtask

    // Monitor for instance A.
    always @(negedge clk) begin
        if (!in_reset) begin
            check("a_ready", int'(bus_a.load_ready), int'(er_a));
            check("a_busy", int'(bus_a.busy), int'(cyc >= bf_a && cyc <= bt_a));
            if (bus_a.ser_valid) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected_bit", 1, 0);
                end else begin
                    e_a = q_a.pop_front();
                    check("a_bit", int'(bus_a.ser_out), int'(e_a.b));
                    check("a_done", int'(bus_a.done), int'(e_a.last));
                    check("a_bit_cycle", cyc, e_a.cyc);
                end
            end else begin
                check("a_idle_ser_out", int'(bus_a.ser_out), 0);
                check("a_idle_done", int'(bus_a.done), 0);
                if (q_a.size() > 0 && q_a[0].cyc <= cyc) begin
                    check("a_missing_bit", 1, 0);
                    void'(q_a.pop_front());
                end
            end
        end
    end

    // Monitor for instance B.
    always @(negedge clk) begin
        if (!in_reset) begin
            check("b_ready", int'(bus_b.load_ready), int'(er_b));
            check("b_busy", int'(bus_b.busy), int'(cyc >= bf_b && cyc <= bt_b));
            if (bus_b.ser_valid) begin
                if (q_b.size() == 0) begin
                    check("b_unexpected_bit", 1, 0);
                end else begin
                    e_b = q_b.pop_front();
                    check("b_bit", int'(bus_b.ser_out), int'(e_b.b));
                    check("b_done", int'(bus_b.done), int'(e_b.last));
                    check("b_bit_cycle", cyc, e_b.cyc);
                end
            end else begin
                check("b_idle_ser_out", int'(bus_b.ser_out), 0);
                check("b_idle_done", int'(bus_b.done), 0);
                if (q_b.size() > 0 && q_b[0].cyc <= cyc) begin
                    check("b_missing_bit", 1, 0);
                    void'(q_b.pop_front());
                end
            end
        end
    end

    initial begin
        bit aa;
        bit ab;
        reset = 1'b0;
        bus_a.load_valid = 1'b0;
        bus_a.data_in    = '0;
        bus_b.load_valid = 1'b0;
        bus_b.data_in    = '0;

        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs();
        release_reset();

        // Single words, then back-to-back words held on valid.
        offer(1'b1, 8'b1001_1001, 1'b1, 4'b0001);
        idle(12);
        offer(1'b1, 8'hA5, 1'b1, 4'hF);
        offer(1'b1, 8'h3C, 1'b1, 4'h6);
        idle(12);

        // Abort a word in flight after its fourth bit.
        offer(1'b1, 8'hF0, 1'b1, 4'hA);
        idle(4);
        @(posedge clk);
        #3;
        in_reset = 1'b1;
        reset = 1'b0;
        #1;
        check_reset_outputs();
        q_a.delete();
        q_b.delete();
        bf_a = 1;
        bt_a = 0;
        bf_b = 1;
        bt_b = 0;
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs();
        release_reset();
        offer(1'b1, 8'h5A, 1'b1, 4'h9);
        idle(12);

        // Random valid toggling and data, including while busy.
        for (int i = 0; i < 400; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), 8'($urandom),
                        1'($urandom_range(0, 1)), 4'($urandom), aa, ab);
        end
        idle(16);
        check("a_drained", q_a.size(), 0);
        check("b_drained", q_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
